// File: rtl/sprite_lut_pkg.sv
// Shared types and constants for the sprite LUT frame loader.
package sprite_lut_pkg;

    localparam int unsigned LUT_DATA_W  = 12;
    localparam int unsigned LUT_ADDR_W  = 10;
    localparam int unsigned LUT_FRAME_W = 2;
    localparam int unsigned FRAME_WORDS = 2**LUT_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        COPY,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [LUT_FRAME_W-1:0] frame;
        logic [LUT_ADDR_W-1:0]  word;
    } src_addr_t;

endpackage

// File: rtl/sprite_lut_loader.sv
// Copies one sprite frame into the colour LUT during vblank and shares the
// LUT write port with single-word CPU writes.
module sprite_lut_loader
    import sprite_lut_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LUT_DATA_W,
    parameter int unsigned ADDR_WIDTH = LUT_ADDR_W,
    parameter int unsigned FRAME_BITS = LUT_FRAME_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_req,
    input  logic [FRAME_BITS-1:0]            frame_sel,
    input  logic                             vblank,
    output logic                             busy,
    output logic                             done,
    output logic [FRAME_BITS-1:0]            cur_frame,
    output logic [FRAME_BITS+ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]            src_data,
    output logic                             lut_we,
    output logic [ADDR_WIDTH-1:0]            lut_addr_w,
    output logic [DATA_WIDTH-1:0]            lut_din,
    input  logic                             cpu_wr,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_data,
    output logic                             cpu_ready
);

    localparam int unsigned N_WORDS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(N_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     i_q, i_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [FRAME_BITS-1:0]   pend_frame_q, pend_frame_d;
    logic [FRAME_BITS-1:0]   cur_frame_q, cur_frame_d;
    logic                    done_q, done_d;
    logic                    lut_we_q, lut_we_d;
    logic [ADDR_WIDTH-1:0]   lut_addr_q, lut_addr_d;
    logic [DATA_WIDTH-1:0]   cpu_data_q, cpu_data_d;
    logic                    sel_copy_q, sel_copy_d;

    logic                    issue;
    logic                    start;
    logic [FRAME_BITS-1:0]   start_frame;
    logic                    cpu_accept;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        frame_d      = frame_q;
        pend_valid_d = pend_valid_q;
        pend_frame_d = pend_frame_q;
        cur_frame_d  = cur_frame_q;
        done_d       = 1'b0;
        lut_we_d     = 1'b0;
        lut_addr_d   = lut_addr_q;
        cpu_data_d   = cpu_data_q;
        sel_copy_d   = 1'b0;
        issue        = 1'b0;
        start        = 1'b0;
        start_frame  = frame_q;
        cpu_ready    = (state_q == IDLE) && !pend_valid_q;
        cpu_accept   = cpu_wr && cpu_ready;

        case (state_q)
            IDLE: begin
                // A fresh request in the done cycle supersedes the queued one.
                if (frame_req) begin
                    start        = 1'b1;
                    start_frame  = frame_sel;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    start        = 1'b1;
                    start_frame  = pend_frame_q;
                    pend_valid_d = 1'b0;
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                if (vblank) begin
                    issue = 1'b1;
                    i_d   = i_q + ONE;
                    if (i_q == LAST_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                cur_frame_d = frame_q;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            frame_d = start_frame;
            i_d     = '0;
            state_d = vblank ? COPY : WAIT_VB;
        end

        if (frame_req && state_q != IDLE) begin
            pend_valid_d = 1'b1;
            pend_frame_d = frame_sel;
        end

        if (issue) begin
            lut_we_d   = 1'b1;
            lut_addr_d = i_q[ADDR_WIDTH-1:0];
            sel_copy_d = 1'b1;
        end else if (cpu_accept) begin
            lut_we_d   = 1'b1;
            lut_addr_d = cpu_addr;
            cpu_data_d = cpu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            i_q          <= '0;
            frame_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_frame_q <= '0;
            cur_frame_q  <= '0;
            done_q       <= 1'b0;
            lut_we_q     <= 1'b0;
            lut_addr_q   <= '0;
            cpu_data_q   <= '0;
            sel_copy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            frame_q      <= frame_d;
            pend_valid_q <= pend_valid_d;
            pend_frame_q <= pend_frame_d;
            cur_frame_q  <= cur_frame_d;
            done_q       <= done_d;
            lut_we_q     <= lut_we_d;
            lut_addr_q   <= lut_addr_d;
            cpu_data_q   <= cpu_data_d;
            sel_copy_q   <= sel_copy_d;
        end
    end

    // The store's read port is itself registered, so copy data is forwarded
    // straight from it in the cycle after the read was issued.
    assign lut_din    = sel_copy_q ? src_data : cpu_data_q;
    assign lut_we     = lut_we_q;
    assign lut_addr_w = lut_addr_q;
    assign src_addr   = {frame_q, i_q[ADDR_WIDTH-1:0]};
    assign busy       = (state_q != IDLE) || done_q || pend_valid_q;
    assign done       = done_q;
    assign cur_frame  = cur_frame_q;

endmodule

// File: tb/tb_sprite_lut_loader.sv
// Bench for sprite_lut_loader: sprite store model, write scoreboard and
// timing checks around vblank, CPU arbitration, queued requests and reset.
module tb_sprite_lut_loader;
    import sprite_lut_pkg::*;

    localparam int unsigned DW = LUT_DATA_W;
    localparam int unsigned AW = LUT_ADDR_W;
    localparam int unsigned FB = LUT_FRAME_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_req;
    logic [FB-1:0] frame_sel;
    logic          vblank;
    logic          busy;
    logic          done;
    logic [FB-1:0] cur_frame;
    logic [FB+AW-1:0] src_addr;
    logic [DW-1:0] src_data = '0;
    logic          lut_we;
    logic [AW-1:0] lut_addr_w;
    logic [DW-1:0] lut_din;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ready;

    sprite_lut_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_BITS (FB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_req  (frame_req),
        .frame_sel  (frame_sel),
        .vblank     (vblank),
        .busy       (busy),
        .done       (done),
        .cur_frame  (cur_frame),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .lut_we     (lut_we),
        .lut_addr_w (lut_addr_w),
        .lut_din    (lut_din),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] store [0:(1<<(FB+AW))-1];

    always @(posedge clk) src_data <= store[src_addr];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    bit  sb_on = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;

    always @(negedge clk) begin
        wr_t e;
        if (sb_on && lut_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %h din %h, required no write", lut_addr_w, lut_din);
            end else begin
                e = exp_q.pop_front();
                if (lut_addr_w !== e.addr || lut_din !== e.data) begin
                    n_err++;
                    $display("FAIL lut_write: got addr %h din %h, required addr %h din %h",
                             lut_addr_w, lut_din, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void push_copy(input int f);
        wr_t e;
        src_addr_t sa;
        for (int i = 0; i < int'(FRAME_WORDS); i++) begin
            sa.frame = FB'(f);
            sa.word  = AW'(i);
            e.addr   = AW'(i);
            e.data   = store[sa];
            exp_q.push_back(e);
        end
    endfunction

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
        check("done_within_budget", done, 1);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int first_we, last_we, n_we, n_done, done_cyc, bad_src, busy_bad, w, w2;

        tbl[0] = '{1'b1, 10'h05A, 12'hF00, 1'b1, 10'h05A, 12'hF00};
        tbl[1] = '{1'b1, 10'h3FF, 12'h0AB, 1'b1, 10'h3FF, 12'h0AB};
        tbl[2] = '{1'b0, 10'h123, 12'h456, 1'b0, 10'h000, 12'h000};
        tbl[3] = '{1'b1, 10'h000, 12'hFFF, 1'b1, 10'h000, 12'hFFF};

        for (int a = 0; a < (1 << (FB + AW)); a++)
            store[a] = DW'((a * 37) ^ (a >> 4) ^ 12'h5A5);

        reset = 1'b1; frame_req = 1'b0; frame_sel = '0; vblank = 1'b1;
        cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
        repeat (3) step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cur_frame", cur_frame, 0);
        check("rst_lut_we", lut_we, 0);
        check("rst_lut_addr_w", lut_addr_w, 0);
        check("rst_lut_din", lut_din, 0);
        check("rst_src_addr", src_addr, 0);
        reset = 1'b0;
        step();
        check("idle_cpu_ready", cpu_ready, 1);

        // CPU single-word writes in IDLE
        for (int v = 0; v < 4; v++) begin
            check("tbl_cpu_ready", cpu_ready, 1);
            cpu_wr = tbl[v].wr; cpu_addr = tbl[v].addr; cpu_data = tbl[v].data;
            step();
            cpu_wr = 1'b0;
            check("tbl_lut_we", lut_we, {31'b0, tbl[v].exp_we});
            if (tbl[v].exp_we) begin
                check("tbl_lut_addr_w", lut_addr_w, {22'b0, tbl[v].exp_addr});
                check("tbl_lut_din", lut_din, {20'b0, tbl[v].exp_din});
            end
        end
        step();
        sb_on = 1'b1;

        // Frame 2 with vblank held high: exact cycle timing
        vblank = 1'b1; frame_req = 1'b1; frame_sel = 2'd2; push_copy(2);
        step();
        frame_req = 1'b0;
        first_we = -1; last_we = -1; n_we = 0; n_done = 0; done_cyc = -1; bad_src = 0; busy_bad = 0;
        for (int k = 1; k <= 1030; k++) begin
            if (k <= 1024 && src_addr !== 12'(32'h800 + k - 1)) bad_src++;
            if (lut_we) begin
                if (first_we < 0) first_we = k;
                last_we = k;
                n_we++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = k;
                n_done++;
            end
            if (busy !== (k <= 1026)) busy_bad++;
            step();
        end
        check("t1_first_we_cycle", first_we, 2);
        check("t1_last_we_cycle", last_we, 1025);
        check("t1_we_count", n_we, 1024);
        check("t1_done_cycle", done_cyc, 1026);
        check("t1_done_pulses", n_done, 1);
        check("t1_src_addr_errors", bad_src, 0);
        check("t1_busy_errors", busy_bad, 0);
        check("t1_cur_frame", cur_frame, 2);
        check("t1_sb_empty", exp_q.size(), 0);

        // Frame 1 requested outside vblank
        vblank = 1'b0; frame_req = 1'b1; frame_sel = 2'd1; push_copy(1);
        step();
        frame_req = 1'b0;
        n_we = 0; busy_bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (lut_we) n_we++;
            if (busy !== 1'b1) busy_bad++;
            step();
        end
        check("t2_no_we_before_vblank", n_we, 0);
        check("t2_busy_while_waiting", busy_bad, 0);
        vblank = 1'b1;
        step();
        check("t2_first_src_addr", src_addr, 12'h400);
        check("t2_no_we_at_first_read", lut_we, 0);
        step();
        check("t2_first_we", lut_we, 1);
        wait_done(1100, w);
        check("t2_cur_frame", cur_frame, 1);
        step();
        check("t2_sb_empty", exp_q.size(), 0);

        // vblank dropped for 20 cycles when word 300 is due
        vblank = 1'b1; frame_req = 1'b1; frame_sel = 2'd0; push_copy(0);
        step();
        frame_req = 1'b0;
        repeat (300) step();
        vblank = 1'b0;
        check("t3_inflight_we", lut_we, 1);
        check("t3_inflight_addr", lut_addr_w, 299);
        n_we = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (lut_we) n_we++;
        end
        vblank = 1'b1;
        check("t3_no_we_while_low", n_we, 0);
        step();
        check("t3_resume_we", lut_we, 1);
        check("t3_resume_addr", lut_addr_w, 300);
        wait_done(1100, w);
        check("t3_cur_frame", cur_frame, 0);
        step();
        check("t3_sb_empty", exp_q.size(), 0);

        // CPU write held during a copy is accepted only in the done cycle
        frame_req = 1'b1; frame_sel = 2'd1; push_copy(1);
        step();
        frame_req = 1'b0;
        step();
        cpu_wr = 1'b1; cpu_addr = 10'h111; cpu_data = 12'h222;
        w = 0;
        while (cpu_ready !== 1'b1 && w < 1100) begin
            step();
            w++;
        end
        check("t4_cpu_ready_after_copy", cpu_ready, 1);
        check("t4_accept_in_done_cycle", done, 1);
        check("t4_cur_frame", cur_frame, 1);
        exp_q.push_back('{10'h111, 12'h222});
        step();
        cpu_wr = 1'b0;
        step();
        check("t4_sb_empty", exp_q.size(), 0);

        // Simultaneous CPU write + request, then queued requests (last wins)
        check("t5_cpu_ready", cpu_ready, 1);
        cpu_wr = 1'b1; cpu_addr = 10'h2AA; cpu_data = 12'h123;
        frame_req = 1'b1; frame_sel = 2'd1;
        exp_q.push_back('{10'h2AA, 12'h123});
        push_copy(1);
        step();
        cpu_wr = 1'b0; frame_req = 1'b0;
        repeat (400) step();
        frame_req = 1'b1; frame_sel = 2'd0;
        step();
        frame_req = 1'b0;
        repeat (99) step();
        check("t5_cpu_blocked_mid_copy", cpu_ready, 0);
        frame_req = 1'b1; frame_sel = 2'd3; push_copy(3);
        step();
        frame_req = 1'b0;
        wait_done(1100, w);
        check("t5_first_done_cur_frame", cur_frame, 1);
        check("t5_busy_in_done_cycle", busy, 1);
        step();
        wait_done(1100, w2);
        check("t5_second_done_gap", w2, 1025);
        check("t5_second_cur_frame", cur_frame, 3);
        step();
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset mid-copy
        frame_req = 1'b1; frame_sel = 2'd2; push_copy(2);
        step();
        frame_req = 1'b0;
        repeat (700) step();
        sb_on = 1'b0;
        reset = 1'b1;
        step();
        check("t6_busy_after_reset", busy, 0);
        check("t6_lut_we_after_reset", lut_we, 0);
        check("t6_cur_frame_after_reset", cur_frame, 0);
        check("t6_done_after_reset", done, 0);
        check("t6_src_addr_after_reset", src_addr, 0);
        reset = 1'b0;
        exp_q.delete();
        step();
        check("t6_no_write_after_reset", lut_we, 0);
        sb_on = 1'b1;
        frame_req = 1'b1; frame_sel = 2'd3; push_copy(3);
        step();
        frame_req = 1'b0;
        wait_done(1100, w);
        check("t6_fresh_cur_frame", cur_frame, 3);
        step();
        check("t6_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_lut_loader.md
Name: sprite_lut_loader

Overview:
- Controller that owns the write port of a sprite colour LUT (12-bit colour, 1024 words, 1-cycle registered read, separate read/write addresses).
- Copies a selected animation frame from a multi-frame sprite store into the LUT, one word per cycle, only during vertical blanking so the pixel path never reads a half-updated sprite.
- Arbitrates the LUT write port between this copy engine and single-word CPU writes from the bus slot.

Parameters:
DATA_WIDTH, 12, colour depth per word
ADDR_WIDTH, 10, LUT address bits; frame size N = 2**ADDR_WIDTH words
FRAME_BITS, 2, frame-select bits; store holds 2**FRAME_BITS frames

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_req  in  1  one-cycle pulse: load frame frame_sel
frame_sel  in  FRAME_BITS  frame index, sampled with frame_req
vblank  in  1  high during vertical blanking
busy  out  1  request pending or copy in progress
done  out  1  one-cycle pulse when a frame copy completes
cur_frame  out  FRAME_BITS  index of the frame last fully loaded
src_addr  out  FRAME_BITS+ADDR_WIDTH  store read address {frame, word}
src_data  in  DATA_WIDTH  store read data, valid 1 cycle after src_addr
lut_we  out  1  LUT write enable
lut_addr_w  out  ADDR_WIDTH  LUT write address
lut_din  out  DATA_WIDTH  LUT write data
cpu_wr  in  1  CPU single-word write strobe
cpu_addr  in  ADDR_WIDTH  CPU write address
cpu_data  in  DATA_WIDTH  CPU write data
cpu_ready  out  1  CPU write accepted when cpu_wr && cpu_ready

Behaviour:
- Reset values: busy=0, done=0, cur_frame=0, lut_we=0, lut_addr_w=0, lut_din=0, src_addr=0. Pending request cleared, state IDLE.
- Reset mid-copy: the copy aborts the same cycle and there is no further lut_we. LUT contents stay partially written; cur_frame returns to 0.
- FSM states: IDLE, WAIT_VB, COPY, DRAIN.
- IDLE:
  - frame_req=1 latches frame_sel into the pending register.
  - Next state is COPY if vblank=1 that cycle, else WAIT_VB.
- WAIT_VB: hold until vblank=1, then go to COPY.
- COPY:
  - Word counter i starts at 0.
  - Each cycle with vblank=1: src_addr={pending,i}, i++.
  - vblank=0: no new read is issued and i holds. A read already in flight still completes its write next cycle.
  - After issuing i=N-1, go to DRAIN.
- DRAIN:
  - The last write occurs this cycle.
  - Next cycle: done=1 for one cycle, cur_frame<=pending, return to IDLE.
- Write pipeline: a read issued at cycle t gives lut_we=1, lut_addr_w=i, lut_din=src_data at t+1. All lut_* outputs are registered.
- Timing with vblank held high and the request at cycle 0:
  - reads are issued at cycles 1..N;
  - lut_we is high at cycles 2..N+1;
  - done pulses at cycle N+2;
  - busy is high at cycles 1..N+2.
- frame_req while busy: frame_sel overwrites the pending-next register (last request wins). That request is serviced immediately after done, with no IDLE gap beyond one cycle.
- CPU arbitration:
  - cpu_ready=1 only in IDLE with no pending request.
  - An accepted CPU write appears on lut_* at the next cycle.
  - If cpu_wr and frame_req arrive in the same IDLE cycle, both are accepted. The CPU write lands at t+1 and the first copy write lands at t+2, so there is no collision.
  - cpu_wr while cpu_ready=0 is ignored; the bus must hold it until ready.
- Counter wrap: i is ADDR_WIDTH+1 bits wide; the terminal compare is against N-1, so no wrap into word 0.
- done and lut_we from copy and CPU are never asserted for the same address in the same cycle.

Decomposition:
- Package sprite_lut_pkg holds:
  - state enum typedef {IDLE, WAIT_VB, COPY, DRAIN};
  - constant FRAME_WORDS=2**ADDR_WIDTH;
  - typedef for the {frame, word} source address.
- No sub-module. The counter, FSM and one-stage write pipeline stay in one module (about 150-200 lines).

Test Plan:
- Reset, then frame_req with frame_sel=2 and vblank held 1 -> src_addr 0x800..0xBFF on cycles 1..1024; lut_we cycles 2..1025 with lut_addr_w=i; done at cycle 1026; cur_frame=2.
- frame_req with frame_sel=1 while vblank=0 for 50 cycles, then 1 -> no lut_we before vblank rises; first src_addr=0x400 the cycle vblank is 1.
- vblank drops at i=300 for 20 cycles -> exactly one more lut_we (addr 299), then none for 20 cycles; resumes at 300; all 1024 addresses written exactly once.
- CPU write addr 0x05A data 0xF00 in IDLE -> lut_we, addr 0x05A, din 0xF00 next cycle. cpu_wr during copy -> cpu_ready=0 and no write until done.
- frame_req sel=3 at copy word 500 -> after done (cur_frame=old), a second copy of frame 3 starts; second done gives cur_frame=3.
- reset asserted at copy word 700 -> next cycle busy=0, lut_we=0, cur_frame=0; a fresh request then completes normally.
